bcd_fract_cvt_arb: RTL and testbench



---
 rtl/bcd_fract_cvt_arb.sv | 166 ++++++++++++++++
 tb/tb_bcd_fract_cvt_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_fract_cvt_arb.sv
// Round-robin arbiter that shares one iterative binary-fraction-to-BCD converter among NREQ requesters.
// Optional watchdog on the converter's done flag: define BCD_FRACT_CVT_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module bcd_fract_cvt_arb #(
  parameter  int NREQ = 4,
  parameter  int WID  = 116,
  localparam int OWID = (WID + (WID - 4) / 3 + 3) & -4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*WID-1:0]  req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [OWID-1:0]      rsp_data,
  output logic                 cvt_ld,
  output logic [WID-1:0]       cvt_i,
  input  logic [OWID-1:0]      cvt_o,
  input  logic                 cvt_done,
  output logic                 busy
`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
  ,
  output logic                 rsp_err
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t              state, state_d;
  logic [IDW-1:0]      rr_ptr, rr_ptr_d;
  logic [IDW-1:0]      id, id_d;
  logic [NREQ-1:0]     req_ready_d;
  logic                rsp_valid_d;
  logic [IDW-1:0]      rsp_id_d;
  logic [OWID-1:0]     rsp_data_d;
  logic                cvt_ld_d;
  logic [WID-1:0]      cvt_i_d;

  logic                gnt_found;
  logic [IDW-1:0]      gnt;
  int                  idx;

`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
  localparam int LIMIT = OWID / 4 + 8;
  localparam int WDW   = $clog2(LIMIT);
  logic [WDW-1:0]      wd, wd_d;
  logic                rsp_err_d;
`endif

  // Circular first-set search starting at rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[IDW'(idx)]) begin
        gnt_found = 1'b1;
        gnt       = IDW'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every target gets a default before the case, so no path can infer a latch.
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    id_d        = id;
    req_ready_d = '0;
    cvt_ld_d    = 1'b0;
    cvt_i_d     = cvt_i;
    rsp_valid_d = rsp_valid;
    rsp_id_d    = rsp_id;
    rsp_data_d  = rsp_data;
`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
    wd_d        = wd;
    rsp_err_d   = rsp_err;
`endif
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready_d[gnt] = 1'b1;
          cvt_ld_d         = 1'b1;
          cvt_i_d          = req_data[int'(gnt)*WID +: WID];
          id_d             = gnt;
          rr_ptr_d         = (int'(gnt) == NREQ - 1) ? '0 : gnt + IDW'(1);
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        // done is still high from the previous idle period here, so it is not sampled.
        state_d = BUSY;
`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      BUSY: begin
        if (cvt_done) begin
          rsp_data_d  = cvt_o;
          rsp_id_d    = id;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (wd == WDW'(LIMIT - 1)) begin
          rsp_data_d  = '0;
          rsp_id_d    = id;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          wd_d        = wd + WDW'(1);
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      cvt_ld    <= 1'b0;
      cvt_i     <= '0;
`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
      wd        <= '0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      id        <= id_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_data  <= rsp_data_d;
      cvt_ld    <= cvt_ld_d;
      cvt_i     <= cvt_i_d;
`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
      wd        <= wd_d;
      rsp_err   <= rsp_err_d;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_fract_cvt_arb.sv
// Bench for bcd_fract_cvt_arb: behavioural converter model, directed vector table and corner-case sequences.
`timescale 1ns/1ps

module tb_bcd_fract_cvt_arb;
  localparam int NREQ  = 4;
  localparam int WID   = 116;
  localparam int OWID  = 156;
  localparam int IDW   = 2;
  localparam int LAT   = OWID / 4;
  localparam int LIMIT = OWID / 4 + 8;

  typedef logic [OWID-1:0] word_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*WID-1:0] req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [IDW-1:0]      rsp_id;
  word_t               rsp_data;
  logic                cvt_ld;
  logic [WID-1:0]      cvt_i;
  word_t               cvt_o;
  logic                cvt_done;
  logic                busy;
`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
  logic                rsp_err;
`endif

  bcd_fract_cvt_arb #(.NREQ(NREQ), .WID(WID)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .cvt_ld(cvt_ld), .cvt_i(cvt_i), .cvt_o(cvt_o), .cvt_done(cvt_done),
    .busy(busy)
`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
    , .rsp_err(rsp_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operands: 0.5, 0.25, 1.0, 0.75 and their hand-computed BCD results.
  logic [WID-1:0] op [NREQ];
  word_t          exp_d [NREQ];
  initial begin
    op[0] = {4'h0, 1'b1, 111'h0};
    op[1] = {4'h0, 2'b01, 110'h0};
    op[2] = {4'h1, 112'h0};
    op[3] = {4'h0, 2'b11, 110'h0};
    exp_d[0] = {4'h0, 4'h5, 148'h0};
    exp_d[1] = {4'h0, 4'h2, 4'h5, 144'h0};
    exp_d[2] = {4'h1, 152'h0};
    exp_d[3] = {4'h0, 4'h7, 4'h5, 144'h0};
  end
  assign req_data = {op[3], op[2], op[1], op[0]};

  // Converter model: digit-by-digit multiply-by-ten of the fraction.
  function automatic word_t cvt_model(input logic [WID-1:0] x);
    word_t          r;
    logic [WID-1:0] f;
    r = '0;
    r[OWID-1 -: 4] = x[WID-1 -: 4];
    f = {4'h0, x[WID-5:0]};
    for (int d = 0; d < (OWID - 4) / 4; d++) begin
      f = (f << 3) + (f << 1);
      r[OWID-5-4*d -: 4] = f[WID-1 -: 4];
      f[WID-1 -: 4] = 4'h0;
    end
    return r;
  endfunction

  logic  hang = 1'b0;
  int    cnt;
  word_t res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cvt_done <= 1'b1;
      cnt      <= 0;
      cvt_o    <= '1;
      res      <= '0;
    end else if (cvt_ld) begin
      cvt_done <= 1'b0;
      cnt      <= LAT;
      res      <= cvt_model(cvt_i);
      cvt_o    <= '1;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (cnt == 1) begin
      cnt <= 0;
      if (!hang) begin
        cvt_done <= 1'b1;
        cvt_o    <= res;
      end
    end
  end

  typedef struct {
    logic [NREQ-1:0] valid;
    int              id;
  } vec_t;
  vec_t tbl [8];

  task automatic wait_grant(output logic got);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
  endtask

  task automatic wait_rsp(output logic got, output int strobes, output int cycles);
    got = 1'b0; strobes = 0; cycles = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      else begin
        cycles++;
        if (cvt_ld || req_ready != '0) strobes++;
      end
    end
  endtask

  task automatic run_txn(input logic [NREQ-1:0] v, input int id);
    logic got;
    int   strobes, cycles;
    req_valid = v;
    wait_grant(got);
    check("grant_seen", word_t'(got), word_t'(1));
    check("req_ready_onehot", word_t'(req_ready), word_t'(1) << id);
    check("cvt_ld_at_grant", word_t'(cvt_ld), word_t'(1));
    check("cvt_i_operand", word_t'(cvt_i), word_t'(op[id]));
    req_valid = '0;
    wait_rsp(got, strobes, cycles);
    check("rsp_seen", word_t'(got), word_t'(1));
    check("single_strobe", word_t'(strobes), word_t'(0));
    check("rsp_id", word_t'(rsp_id), word_t'(id));
    check("rsp_data", rsp_data, exp_d[id]);
`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
    check("rsp_err_normal", word_t'(rsp_err), word_t'(0));
`endif
    @(negedge clk);
    check("rsp_valid_drop", word_t'(rsp_valid), word_t'(0));
    check("idle_after_rsp", word_t'(busy), word_t'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500us;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    logic  got;
    int    strobes, cycles, viol;
    word_t hold_data;
    logic [IDW-1:0] hold_id;

    tbl[0] = '{4'b0001, 0};
    tbl[1] = '{4'b0100, 2};
    tbl[2] = '{4'b1111, 3};
    tbl[3] = '{4'b0110, 1};
    tbl[4] = '{4'b1011, 3};
    tbl[5] = '{4'b1010, 1};
    tbl[6] = '{4'b0011, 0};
    tbl[7] = '{4'b1000, 3};

    #12;
    check("rst_req_ready", word_t'(req_ready), word_t'(0));
    check("rst_rsp_valid", word_t'(rsp_valid), word_t'(0));
    check("rst_rsp_id", word_t'(rsp_id), word_t'(0));
    check("rst_rsp_data", rsp_data, word_t'(0));
    check("rst_cvt_ld", word_t'(cvt_ld), word_t'(0));
    check("rst_cvt_i", word_t'(cvt_i), word_t'(0));
    check("rst_busy", word_t'(busy), word_t'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) run_txn(tbl[t].valid, tbl[t].id);

    // Round robin from reset with every requester held.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(got);
      check("rr_grant", word_t'(req_ready), word_t'(1) << (k % 4));
      wait_rsp(got, strobes, cycles);
      if (k == 4) req_valid = '0;
      check("rr_rsp_id", word_t'(rsp_id), word_t'(k % 4));
      check("rr_rsp_data", rsp_data, exp_d[k % 4]);
    end
    @(negedge clk);

    // Backpressure: 20 stalled cycles with every requester pending.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    wait_grant(got);
    check("bp_grant", word_t'(req_ready), word_t'(4'b0010));
    req_valid = 4'b1111;
    wait_rsp(got, strobes, cycles);
    check("bp_rsp_seen", word_t'(got), word_t'(1));
    hold_data = rsp_data;
    hold_id   = rsp_id;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== hold_data || rsp_id !== hold_id || cvt_ld || req_ready != '0)
        viol++;
    end
    check("bp_stall_stable", word_t'(viol), word_t'(0));
    check("bp_rsp_id", word_t'(hold_id), word_t'(1));
    check("bp_rsp_data", hold_data, exp_d[1]);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", word_t'(rsp_valid), word_t'(0));
    check("bp_release_idle", word_t'(busy), word_t'(0));
    @(negedge clk);
    check("bp_next_grant", word_t'(req_ready), word_t'(4'b0100));
    req_valid = '0;
    wait_rsp(got, strobes, cycles);
    check("bp_next_rsp_id", word_t'(rsp_id), word_t'(2));
    @(negedge clk);

    // Reset while BUSY, after moving rr_ptr away from 0.
    req_valid = 4'b0100;
    wait_grant(got);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("mid_busy", word_t'(busy), word_t'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", word_t'(busy), word_t'(0));
    check("mid_rst_req_ready", word_t'(req_ready), word_t'(0));
    check("mid_rst_rsp_valid", word_t'(rsp_valid), word_t'(0));
    check("mid_rst_cvt_ld", word_t'(cvt_ld), word_t'(0));
    check("mid_rst_cvt_i", word_t'(cvt_i), word_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (rsp_valid) viol++;
    end
    check("mid_rst_no_rsp", word_t'(viol), word_t'(0));
    run_txn(4'b1111, 0);

`ifdef BCD_FRACT_CVT_ARB_TIMEOUT_EN
    // Converter never completes: watchdog answers with an error result.
    hang = 1'b1;
    req_valid = 4'b0001;
    wait_grant(got);
    req_valid = '0;
    wait_rsp(got, strobes, cycles);
    check("to_rsp_seen", word_t'(got), word_t'(1));
    check("to_busy_cycles", word_t'(cycles), word_t'(LIMIT));
    check("to_rsp_err", word_t'(rsp_err), word_t'(1));
    check("to_rsp_data", rsp_data, word_t'(0));
    check("to_rsp_id", word_t'(rsp_id), word_t'(0));
    @(negedge clk);
    hang = 1'b0;
    run_txn(4'b1000, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
